// File: rtl/sm4_pkg.sv
// Shared types and constants for the SM4 word-serial front end.
// Optional CBC chaining is enabled by defining SM4_CBC_EN; without it only ECB is built.
// Holds the FSM state encoding, stream word types and the wait limits.
package sm4_pkg;

    localparam int WORD_W           = 32;
    localparam int BLK_W            = 128;
    localparam int WORDS_PER_BLK    = BLK_W / WORD_W;
    localparam int WAIT_HI_LIM      = 4;
    localparam int CORE_TIMEOUT_DEF = 63;

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        ISSUE   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        OUT     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        TYPE_DATA = 2'b00,
        TYPE_KEY  = 2'b01,
        TYPE_IV   = 2'b10,
        TYPE_RSVD = 2'b11
    } stype_t;

    // Word types the current build knows how to assemble; IV only exists with chaining.
    function automatic logic type_legal(input logic [1:0] t);
`ifdef SM4_CBC_EN
        return t != TYPE_RSVD;
`else
        return (t == TYPE_DATA) || (t == TYPE_KEY);
`endif
    endfunction

endpackage

// File: rtl/sm4_word_pack.sv
// Purpose: packs four 32-bit words (first word -> bits [127:96]) into a 128-bit group with type check.
// Latency: group completion and errors are flagged combinationally in the cycle the 4th/bad word is accepted.
// Backpressure: none of its own; the parent qualifies acc_i with its ready.
module sm4_word_pack
    import sm4_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              acc_i,
    input  logic [WORD_W-1:0] dat_i,
    input  logic [1:0]        type_i,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        type_o,
    output logic [BLK_W-1:0]  blk_o
);

    logic [BLK_W-1:0] shift_q, shift_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [1:0]       type_q, type_d;

    // The finished group is the held words plus the word arriving now.
    assign blk_o  = {shift_q[BLK_W-WORD_W-1:0], dat_i};
    assign type_o = type_q;

    // Accept a word: latch type on the first word, abort the group on an illegal or changed type.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        done_o  = 1'b0;
        err_o   = 1'b0;
        if (acc_i) begin
            if (!type_legal(type_i) || ((cnt_q != 2'd0) && (type_i != type_q))) begin
                // Partial group is thrown away together with the offending word.
                err_o = 1'b1;
                cnt_d = 2'd0;
            end else begin
                shift_d = blk_o;
                type_d  = type_i;
                if (cnt_q == 2'(WORDS_PER_BLK - 1)) begin
                    done_o = 1'b1;
                    cnt_d  = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_q <= '0;
            cnt_q   <= 2'd0;
            type_q  <= 2'd0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
        end
    end

endmodule

// File: rtl/sm4_word_if.sv
// Purpose: word-serial front end for the SM4 core (pack key/IV/data, strobe core, serialise result); CBC with SM4_CBC_EN.
// Latency: last input word at cycle 0 -> strobes at cycle 1; result captured when busy falls, m_valid the cycle after.
// Backpressure: one block in flight, s_ready low from issue until the 4th output word transfers; m_data held until m_ready.
module sm4_word_if
    import sm4_pkg::*;
#(
    parameter int CORE_TIMEOUT = CORE_TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [31:0]  s_data,
    input  logic [1:0]   s_type,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [31:0]  m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         m_last,
    output logic         err,
    output logic [127:0] core_din,
    output logic [127:0] core_kin,
    output logic         core_drdy,
    output logic         core_krdy,
    input  logic [127:0] core_dout,
    input  logic         core_dvld,
    input  logic         core_kvld,
    input  logic         core_bsy
);

    localparam int TW = $clog2(CORE_TIMEOUT + 1);

    state_t           state_q;
    logic             s_rdy_q;
    logic             err_q;
    logic             core_drdy_q;
    logic             core_krdy_q;
    logic [BLK_W-1:0] core_din_q;
    logic [BLK_W-1:0] core_kin_q;
    logic [BLK_W-1:0] key_q;
    logic             key_ok_q;
    logic [TW-1:0]    tmo_q;
    logic [BLK_W-1:0] out_q;
    logic [1:0]       out_cnt_q;
    logic             m_vld_q;
`ifdef SM4_CBC_EN
    logic [BLK_W-1:0] chain_q;
`endif

    logic             pk_acc;
    logic             pk_done;
    logic             pk_err;
    logic [1:0]       pk_type;
    logic [BLK_W-1:0] pk_blk;

    // The key is reloaded with every block, so the core's key-valid flag carries no information here.
    logic unused_kvld;
    assign unused_kvld = core_kvld;

    assign pk_acc = s_valid && s_rdy_q;

    sm4_word_pack u_pack (
        .clk    (clk),
        .rstn   (rstn),
        .acc_i  (pk_acc),
        .dat_i  (s_data),
        .type_i (s_type),
        .done_o (pk_done),
        .err_o  (pk_err),
        .type_o (pk_type),
        .blk_o  (pk_blk)
    );

    assign s_ready   = s_rdy_q;
    assign err       = err_q;
    assign core_drdy = core_drdy_q;
    assign core_krdy = core_krdy_q;
    assign core_din  = core_din_q;
    assign core_kin  = core_kin_q;
    assign m_valid   = m_vld_q;
    assign m_data    = out_q[BLK_W-1 -: WORD_W];
    assign m_last    = m_vld_q && (out_cnt_q == 2'(WORDS_PER_BLK - 1));

    // Block sequencer: collect groups, issue to the core, supervise busy, then stream the result out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= COLLECT;
            s_rdy_q     <= 1'b1;
            err_q       <= 1'b0;
            core_drdy_q <= 1'b0;
            core_krdy_q <= 1'b0;
            core_din_q  <= '0;
            core_kin_q  <= '0;
            key_q       <= '0;
            key_ok_q    <= 1'b0;
            tmo_q       <= '0;
            out_q       <= '0;
            out_cnt_q   <= 2'd0;
            m_vld_q     <= 1'b0;
`ifdef SM4_CBC_EN
            chain_q     <= '0;
`endif
        end else begin
            // Pulses and strobes last exactly one cycle unless re-asserted below.
            err_q       <= 1'b0;
            core_drdy_q <= 1'b0;
            core_krdy_q <= 1'b0;
            case (state_q)
                COLLECT: begin
                    if (pk_err) begin
                        err_q <= 1'b1;
                    end
                    if (pk_done) begin
                        case (pk_type)
                            TYPE_KEY: begin
                                key_q    <= pk_blk;
                                key_ok_q <= 1'b1;
                            end
`ifdef SM4_CBC_EN
                            TYPE_IV: begin
                                chain_q <= pk_blk;
                            end
`endif
                            TYPE_DATA: begin
                                if (key_ok_q) begin
                                    // Core corrupts its key during rounds: reload it with every block.
`ifdef SM4_CBC_EN
                                    core_din_q <= pk_blk ^ chain_q;
`else
                                    core_din_q <= pk_blk;
`endif
                                    core_kin_q  <= key_q;
                                    core_drdy_q <= 1'b1;
                                    core_krdy_q <= 1'b1;
                                    s_rdy_q     <= 1'b0;
                                    state_q     <= ISSUE;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            default: begin
                                err_q <= 1'b1;
                            end
                        endcase
                    end
                end
                ISSUE: begin
                    tmo_q   <= '0;
                    state_q <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (core_bsy) begin
                        // Busy already seen high once, so the WAIT_LO count starts at one.
                        tmo_q   <= TW'(1);
                        state_q <= WAIT_LO;
                    end else if (tmo_q == TW'(WAIT_HI_LIM - 1)) begin
                        err_q   <= 1'b1;
                        s_rdy_q <= 1'b1;
                        state_q <= COLLECT;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                WAIT_LO: begin
                    // core_dvld is sticky, so completion is the busy fall, qualified by dvld.
                    if (!core_bsy && core_dvld) begin
                        out_q     <= core_dout;
                        out_cnt_q <= 2'd0;
                        m_vld_q   <= 1'b1;
                        state_q   <= OUT;
`ifdef SM4_CBC_EN
                        chain_q   <= core_dout;
`endif
                    end else if (tmo_q == TW'(CORE_TIMEOUT)) begin
                        err_q   <= 1'b1;
                        s_rdy_q <= 1'b1;
                        state_q <= COLLECT;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        out_q <= {out_q[BLK_W-WORD_W-1:0], {WORD_W{1'b0}}};
                        if (out_cnt_q == 2'(WORDS_PER_BLK - 1)) begin
                            m_vld_q <= 1'b0;
                            s_rdy_q <= 1'b1;
                            state_q <= COLLECT;
                        end else begin
                            out_cnt_q <= out_cnt_q + 2'd1;
                        end
                    end
                end
                default: begin
                    s_rdy_q <= 1'b1;
                    state_q <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm4_word_if.sv
module tb_sm4_word_if;
    import sm4_pkg::*;

    localparam int CORE_TIMEOUT = 63;
    localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] PT  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;

    logic         clk = 1'b0;
    logic         rstn;
    logic [31:0]  s_data;
    logic [1:0]   s_type;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;
    logic         err;
    logic [127:0] core_din;
    logic [127:0] core_kin;
    logic         core_drdy;
    logic         core_krdy;
    logic [127:0] core_dout;
    logic         core_dvld;
    logic         core_kvld;
    logic         core_bsy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sm4_word_if #(.CORE_TIMEOUT(CORE_TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .s_data(s_data), .s_type(s_type), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .err(err),
        .core_din(core_din), .core_kin(core_kin), .core_drdy(core_drdy), .core_krdy(core_krdy),
        .core_dout(core_dout), .core_dvld(core_dvld), .core_kvld(core_kvld), .core_bsy(core_bsy)
    );

    // Behavioural core: the standard vector maps to its known ciphertext, other blocks to a fixed scramble.
    function automatic logic [127:0] core_f(input logic [127:0] k, input logic [127:0] d);
        if (k == KEY && d == PT) return CT;
        return {d[95:0], d[127:96]} ^ k ^ 128'h3c3c_a5a5_0f0f_9696_c3c3_5a5a_f0f0_6969;
    endfunction

    int           core_lat  = 8;
    logic         core_mute = 1'b0;
    int           busy_left;
    logic [127:0] pend;

    // Core model: busy for core_lat cycles after a strobe, then dvld (sticky) with the result.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            core_bsy <= 1'b0; core_dvld <= 1'b0; core_kvld <= 1'b0;
            core_dout <= '0; pend <= '0; busy_left <= 0;
        end else if (core_drdy && !core_mute) begin
            core_bsy <= 1'b1; busy_left <= core_lat; core_kvld <= core_krdy;
            pend <= core_f(core_kin, core_din);
        end else if (core_bsy) begin
            if (busy_left > 1) busy_left <= busy_left - 1;
            else begin core_bsy <= 1'b0; core_dvld <= 1'b1; core_dout <= pend; end
        end
    end

    int           err_seen   = 0;
    int           drdy_seen  = 0;
    int           strobe_bad = 0;
    logic         drdy_prev  = 1'b0;
    logic [127:0] mon_din    = '0;
    logic [127:0] mon_kin    = '0;

    // Monitor: count error pulses and strobes, flag wide or unpaired strobes.
    always @(negedge clk) begin
        if (err === 1'b1) err_seen <= err_seen + 1;
        if (core_drdy === 1'b1) begin
            drdy_seen <= drdy_seen + 1; mon_din <= core_din; mon_kin <= core_kin;
        end
        if ((core_drdy !== core_krdy) || (core_drdy === 1'b1 && drdy_prev === 1'b1))
            strobe_bad <= strobe_bad + 1;
        drdy_prev <= core_drdy;
    end

    task automatic send_word(input logic [31:0] d, input logic [1:0] t);
        int n = 0;
        s_valid = 1'b1; s_data = d; s_type = t;
        while (s_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL send_word_timeout: s_ready=%b required 1", s_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_block(input logic [127:0] b, input logic [1:0] t);
        for (int i = 0; i < 4; i++) send_word(b[127-32*i -: 32], t);
        s_valid = 1'b0;
    endtask

    task automatic recv_block(output logic [127:0] blk, output logic [3:0] lst, output int span);
        int n = 0;
        blk = '0; lst = '0; span = 0; m_ready = 1'b1;
        while (m_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin
            n_cmp++; n_bad++; m_ready = 1'b0;
            $display("FAIL recv_timeout: m_valid=%b required 1", m_valid);
            return;
        end
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (m_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; span++; end
            blk = {blk[95:0], m_data}; lst = {lst[2:0], m_last};
            @(negedge clk); span++;
        end
        m_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        rstn = 1'b0; @(negedge clk); rstn = 1'b1; @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; repeat (3) @(negedge clk);
        rstn = 1'b1; @(negedge clk);
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL rst_s_ready: got %b required 1", s_ready); end
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_m_valid: got %b required 0", m_valid); end
        n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL rst_m_last: got %b required 0", m_last); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b required 0", err); end
        n_cmp++; if (core_drdy !== 1'b0) begin n_bad++; $display("FAIL rst_drdy: got %b required 0", core_drdy); end
        n_cmp++; if (core_krdy !== 1'b0) begin n_bad++; $display("FAIL rst_krdy: got %b required 0", core_krdy); end
        n_cmp++; if (core_din !== 128'h0) begin n_bad++; $display("FAIL rst_core_din: got %h required 0", core_din); end
        n_cmp++; if (core_kin !== 128'h0) begin n_bad++; $display("FAIL rst_core_kin: got %h required 0", core_kin); end
    endtask

    task automatic test_no_key();
        int e0 = err_seen;
        int d0 = drdy_seen;
        send_block(PT, TYPE_DATA);
        repeat (3) @(negedge clk);
        n_cmp++; if (err_seen - e0 !== 1) begin n_bad++; $display("FAIL nokey_err: got %0d pulses required 1", err_seen - e0); end
        n_cmp++; if (drdy_seen !== d0) begin n_bad++; $display("FAIL nokey_drdy: got %0d strobes required 0", drdy_seen - d0); end
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL nokey_s_ready: got %b required 1", s_ready); end
    endtask

    task automatic test_ecb();
        int e0 = err_seen;
        int d0 = drdy_seen;
        int n = 0;
        logic [127:0] rb; logic [3:0] rl; int rs;
        core_lat = 8;
        send_block(KEY, TYPE_KEY);
        send_block(PT, TYPE_DATA);
        // One cycle after the last word: ISSUE, both strobes up, input closed.
        n_cmp++; if ({core_drdy, core_krdy, s_ready} !== 3'b110) begin n_bad++; $display("FAIL ecb_issue: got drdy/krdy/s_ready=%b required 110", {core_drdy, core_krdy, s_ready}); end
        // busy sampled high for core_lat cycles from ISSUE+1, low at ISSUE+core_lat+1, m_valid one later.
        while (m_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        n_cmp++; if (n !== core_lat + 2) begin n_bad++; $display("FAIL ecb_latency: got %0d cycles required %0d", n, core_lat + 2); end
        recv_block(rb, rl, rs);
        n_cmp++; if (rb !== CT) begin n_bad++; $display("FAIL ecb_data: got %h required %h", rb, CT); end
        n_cmp++; if (rl !== 4'b0001) begin n_bad++; $display("FAIL ecb_last: got %b required 0001", rl); end
        n_cmp++; if (rs !== 4) begin n_bad++; $display("FAIL ecb_no_bubble: got %0d cycles required 4", rs); end
        n_cmp++; if ({s_ready, m_valid} !== 2'b10) begin n_bad++; $display("FAIL ecb_return: got s_ready/m_valid=%b required 10", {s_ready, m_valid}); end
        n_cmp++; if (mon_din !== PT || mon_kin !== KEY) begin n_bad++; $display("FAIL ecb_core_in: got din %h kin %h", mon_din, mon_kin); end
        n_cmp++; if (drdy_seen - d0 !== 1 || strobe_bad !== 0) begin n_bad++; $display("FAIL ecb_strobes: got %0d strobes, %0d bad, required 1 and 0", drdy_seen - d0, strobe_bad); end
        n_cmp++; if (err_seen !== e0) begin n_bad++; $display("FAIL ecb_err: got %0d pulses required 0", err_seen - e0); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        logic [127:0] rb; logic [3:0] rl; int rs;
        send_block(PT, TYPE_DATA);
        while (m_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if ({m_valid, m_data} !== {1'b1, 32'h681edf34}) begin n_bad++; $display("FAIL bp_hold: got valid %b data %h required 1 681edf34", m_valid, m_data); end
            @(negedge clk);
        end
        recv_block(rb, rl, rs);
        n_cmp++; if (rb !== CT || rl !== 4'b0001) begin n_bad++; $display("FAIL bp_data: got %h last %b required %h 0001", rb, rl, CT); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] rb; logic [3:0] rl; int rs;
        for (int k = 0; k < 2; k++) begin
            send_block(PT, TYPE_DATA);
            recv_block(rb, rl, rs);
            n_cmp++; if (rb !== CT || s_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_%0d: got %h s_ready %b required %h 1", k, rb, s_ready, CT); end
        end
    endtask

    task automatic test_type_switch();
        int e0;
        logic [127:0] kb = KEY;
        logic [127:0] pb = PT;
        logic [127:0] rb; logic [3:0] rl; int rs;
        pulse_reset();
        e0 = err_seen;
        send_word(pb[127:96], TYPE_DATA);
        send_word(pb[95:64], TYPE_DATA);
        send_word(kb[127:96], TYPE_KEY);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (err_seen - e0 !== 1 || s_ready !== 1'b1) begin n_bad++; $display("FAIL switch_err: got %0d pulses s_ready %b required 1 1", err_seen - e0, s_ready); end
        send_word(32'h0, TYPE_IV);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (err_seen - e0 !== 2) begin n_bad++; $display("FAIL iv_in_ecb: got %0d pulses required 2", err_seen - e0); end
        send_block(KEY, TYPE_KEY);
        send_block(PT, TYPE_DATA);
        recv_block(rb, rl, rs);
        n_cmp++; if (rb !== CT || err_seen - e0 !== 2) begin n_bad++; $display("FAIL switch_recover: got %h errs %0d required %h 2", rb, err_seen - e0, CT); end
    endtask

    task automatic test_no_busy();
        int n = 0;
        core_mute = 1'b1;
        send_block(PT, TYPE_DATA);
        // busy checked on WAIT_HI_LIM cycles after ISSUE; err registered one cycle after the last.
        while (err !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        n_cmp++; if (n !== WAIT_HI_LIM + 1) begin n_bad++; $display("FAIL nobusy_err_cycle: got %0d required %0d", n, WAIT_HI_LIM + 1); end
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL nobusy_s_ready: got %b required 1", s_ready); end
        core_mute = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n = 0;
        int e0;
        logic [127:0] rb; logic [3:0] rl; int rs;
        core_lat = 70;
        send_block(PT, TYPE_DATA);
        e0 = err_seen;
        // busy tolerated for CORE_TIMEOUT sampled cycles (ISSUE+1..ISSUE+63), abort at ISSUE+64, err at ISSUE+65.
        while (err !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        n_cmp++; if (n !== CORE_TIMEOUT + 2) begin n_bad++; $display("FAIL tmo_err_cycle: got %0d required %0d", n, CORE_TIMEOUT + 2); end
        n_cmp++; if ({s_ready, m_valid} !== 2'b10) begin n_bad++; $display("FAIL tmo_return: got s_ready/m_valid=%b required 10", {s_ready, m_valid}); end
        n = 0;
        while (core_bsy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        // Exactly CORE_TIMEOUT busy cycles is still a good block.
        core_lat = CORE_TIMEOUT;
        send_block(PT, TYPE_DATA);
        recv_block(rb, rl, rs);
        n_cmp++; if (rb !== CT || err_seen - e0 !== 1) begin n_bad++; $display("FAIL tmo_recover: got %h errs %0d required %h 1", rb, err_seen - e0, CT); end
        core_lat = 8;
    endtask

    task automatic test_reset_mid();
        int e0;
        int d0;
        core_lat = 40;
        send_block(PT, TYPE_DATA);
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        #1;
        n_cmp++; if ({s_ready, m_valid, err, core_drdy} !== 4'b1000) begin n_bad++; $display("FAIL midrst_ctl: got %b required 1000", {s_ready, m_valid, err, core_drdy}); end
        n_cmp++; if (core_din !== 128'h0 || core_kin !== 128'h0) begin n_bad++; $display("FAIL midrst_core: got din %h kin %h required 0", core_din, core_kin); end
        @(negedge clk);
        rstn = 1'b1;
        core_lat = 8;
        @(negedge clk);
        e0 = err_seen; d0 = drdy_seen;
        send_block(PT, TYPE_DATA);
        repeat (3) @(negedge clk);
        n_cmp++; if (err_seen - e0 !== 1 || drdy_seen !== d0) begin n_bad++; $display("FAIL midrst_key_cleared: got errs %0d strobes %0d required 1 0", err_seen - e0, drdy_seen - d0); end
    endtask

`ifdef SM4_CBC_EN
    task automatic test_cbc();
        logic [127:0] rb; logic [3:0] rl; int rs;
        logic [127:0] exp2;
        pulse_reset();
        core_lat = 8;
        send_block(KEY, TYPE_KEY);
        send_block(128'h0, TYPE_IV);
        send_block(PT, TYPE_DATA);
        recv_block(rb, rl, rs);
        n_cmp++; if (rb !== CT) begin n_bad++; $display("FAIL cbc_first: got %h required %h", rb, CT); end
        send_block(PT, TYPE_DATA);
        n_cmp++; if (mon_din !== (PT ^ CT)) begin n_bad++; $display("FAIL cbc_din: got %h required %h", mon_din, PT ^ CT); end
        exp2 = core_f(KEY, PT ^ CT);
        recv_block(rb, rl, rs);
        n_cmp++; if (rb !== exp2 || rb === CT) begin n_bad++; $display("FAIL cbc_second: got %h required %h", rb, exp2); end
    endtask
`endif

    initial begin
        rstn = 1'b0; s_valid = 1'b0; s_data = '0; s_type = '0; m_ready = 1'b0;
        test_reset();
        test_no_key();
`ifdef SM4_CBC_EN
        test_cbc();
`else
        test_ecb();
        test_backpressure();
        test_back_to_back();
        test_type_switch();
        test_no_busy();
        test_timeout();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
